// File: rtl/dma_stream_arbiter.sv
// dma_stream_arbiter: round-robin packet arbiter sharing one DMA stream among NUM_IN length-prefixed sources
//   clk       system clock
//   reset     asynchronous active-low reset
//   in_data   packed input words, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid  per-input valid
//   in_ready  per-input ready, only the granted input can see out_ready
//   out_data  word to the DMA
//   out_valid output valid
//   out_ready DMA ready
//   out_last  final beat of the current packet
//   out_keep  byte enables, all-ones while out_valid
//   grant     one-hot channel owner, zero when idle
//   busy      high while a packet is in progress
//   pkt_count completed packets, wraps
module dma_stream_arbiter #(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic [DATA_WIDTH/8-1:0]      out_keep,
    output logic [NUM_IN-1:0]            grant,
    output logic                         busy,
    output logic [31:0]                  pkt_count
);
    localparam int PW = $clog2(NUM_IN);
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
    state_t                state, state_n;
    logic [NUM_IN-1:0]     grant_n;
    logic [PW-1:0]         rr_ptr, rr_n, win, cand;
    logic [DATA_WIDTH-1:0] remaining, remaining_n;
    logic [31:0]           pkt_n;
    logic                  found, fire, done;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= PW'(NUM_IN - 1);
            remaining <= '0;
            pkt_count <= '0;
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            rr_ptr    <= rr_n;
            remaining <= remaining_n;
            pkt_count <= pkt_n;
        end
    end
    // Grant is one-hot, so OR-ing the gated words is a plain mux.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_IN; i++)
            if (grant[i]) out_data = out_data | in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    assign out_valid = |(in_valid & grant);
    assign in_ready  = out_ready ? grant : '0;
    assign out_keep  = out_valid ? '1 : '0;
    assign busy      = state != IDLE;
    assign fire      = out_valid && out_ready;
    assign out_last  = state == HEADER  ? out_data <= DATA_WIDTH'(1) :
                       state == PAYLOAD ? remaining == DATA_WIDTH'(1) : 1'b0;
    assign done      = fire && out_last;
    // Scan starts just after the last winner, so the last served input ranks lowest.
    always_comb begin
        found = 1'b0;
        win   = rr_ptr;
        cand  = rr_ptr;
        for (int k = 1; k <= NUM_IN; k++) begin
            cand = PW'((int'(rr_ptr) + k) % NUM_IN);
            if (!found && in_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end
    always_comb begin
        state_n     = state;
        grant_n     = grant;
        rr_n        = rr_ptr;
        remaining_n = remaining;
        pkt_n       = pkt_count;
        case (state)
            IDLE: if (found) begin
                grant_n      = '0;
                grant_n[win] = 1'b1;
                rr_n         = win;
                state_n      = HEADER;
            end
            HEADER: if (fire && !done) begin
                remaining_n = out_data - DATA_WIDTH'(1);
                state_n     = PAYLOAD;
            end
            PAYLOAD: if (fire) remaining_n = remaining - DATA_WIDTH'(1);
            default: state_n = IDLE;
        endcase
        if (done) begin
            state_n = IDLE;
            grant_n = '0;
            pkt_n   = pkt_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_dma_stream_arbiter.sv
// tb_dma_stream_arbiter: directed vector bench for dma_stream_arbiter
module tb_dma_stream_arbiter;
    logic         clk = 1'b0, reset = 1'b0, out_ready = 1'b1;
    logic [127:0] in_data = '0;
    logic [3:0]   in_valid = '0, in_ready, grant, out_keep;
    logic [31:0]  out_data, pkt_count;
    logic         out_valid, out_last, busy;
    int           tests = 0, fails = 0;
    typedef struct {
        logic r; logic [3:0] v; logic [127:0] d; logic o;
        logic [3:0] g; logic ov; logic [31:0] od; logic ol; logic [3:0] ir; logic b; logic [31:0] c;
    } vec_t;
    vec_t        vecs[$];
    logic [31:0] w[5] = '{32'd5, 32'h51, 32'h52, 32'h53, 32'h54};

    dma_stream_arbiter #(.NUM_IN(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .out_keep(out_keep), .grant(grant), .busy(busy), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [127:0] d, input logic o);
        @(negedge clk);
        reset = r; in_valid = v; in_data = d; out_ready = o;
        #1;
    endtask

    function automatic void add(logic r, logic [3:0] v, logic [31:0] d3, logic [31:0] d2, logic [31:0] d1,
                                logic [31:0] d0, logic o, logic [3:0] g, logic ov, logic [31:0] od,
                                logic ol, logic [3:0] ir, logic b, logic [31:0] c);
        vecs.push_back('{r, v, {d3, d2, d1, d0}, o, g, ov, od, ol, ir, b, c});
    endfunction

    initial begin
        // reset state with valids present, then single 4-beat packet on in0
        add(0, 4'hF, 4, 4, 4, 4, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0);
        add(0, 4'hF, 4, 4, 4, 4, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0);
        add(1, 4'h1, 0, 0, 0, 4, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0);
        add(1, 4'h1, 0, 0, 0, 4, 1, 4'h1, 1, 4, 0, 4'h1, 1, 0);
        add(1, 4'h1, 0, 0, 0, 'hA0, 1, 4'h1, 1, 'hA0, 0, 4'h1, 1, 0);
        add(1, 4'h1, 0, 0, 0, 'hB0, 1, 4'h1, 1, 'hB0, 0, 4'h1, 1, 0);
        add(1, 4'h1, 0, 0, 0, 'hC0, 1, 4'h1, 1, 'hC0, 1, 4'h1, 1, 0);
        add(1, 4'h0, 0, 0, 0, 0, 1, 4'h0, 0, 0, 0, 4'h0, 0, 1);
        // reset, then round-robin over four 2-beat packets and back to in0
        add(0, 4'h0, 0, 0, 0, 0, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0);
        add(1, 4'hF, 2, 2, 2, 2, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0);
        add(1, 4'hF, 2, 2, 2, 2, 1, 4'h1, 1, 2, 0, 4'h1, 1, 0);
        add(1, 4'hF, 2, 2, 2, 'hD0, 1, 4'h1, 1, 'hD0, 1, 4'h1, 1, 0);
        add(1, 4'hF, 2, 2, 2, 2, 1, 4'h0, 0, 0, 0, 4'h0, 0, 1);
        add(1, 4'hF, 2, 2, 2, 2, 1, 4'h2, 1, 2, 0, 4'h2, 1, 1);
        add(1, 4'hF, 2, 2, 'hD1, 2, 1, 4'h2, 1, 'hD1, 1, 4'h2, 1, 1);
        add(1, 4'hF, 2, 2, 2, 2, 1, 4'h0, 0, 0, 0, 4'h0, 0, 2);
        add(1, 4'hF, 2, 2, 2, 2, 1, 4'h4, 1, 2, 0, 4'h4, 1, 2);
        add(1, 4'hF, 2, 'hD2, 2, 2, 1, 4'h4, 1, 'hD2, 1, 4'h4, 1, 2);
        add(1, 4'hF, 2, 2, 2, 2, 1, 4'h0, 0, 0, 0, 4'h0, 0, 3);
        add(1, 4'hF, 2, 2, 2, 2, 1, 4'h8, 1, 2, 0, 4'h8, 1, 3);
        add(1, 4'hF, 'hD3, 2, 2, 2, 1, 4'h8, 1, 'hD3, 1, 4'h8, 1, 3);
        add(1, 4'hF, 2, 2, 2, 2, 1, 4'h0, 0, 0, 0, 4'h0, 0, 4);
        add(1, 4'hF, 2, 2, 2, 2, 1, 4'h1, 1, 2, 0, 4'h1, 1, 4);
        add(1, 4'hF, 2, 2, 2, 'hD0, 1, 4'h1, 1, 'hD0, 1, 4'h1, 1, 4);
        add(1, 4'h0, 0, 0, 0, 0, 1, 4'h0, 0, 0, 0, 4'h0, 0, 5);
        // header-only packets on in2: L=0 then L=1
        add(1, 4'h4, 0, 0, 0, 0, 1, 4'h0, 0, 0, 0, 4'h0, 0, 5);
        add(1, 4'h4, 0, 0, 0, 0, 1, 4'h4, 1, 0, 1, 4'h4, 1, 5);
        add(1, 4'h4, 0, 1, 0, 0, 1, 4'h0, 0, 0, 0, 4'h0, 0, 6);
        add(1, 4'h4, 0, 1, 0, 0, 1, 4'h4, 1, 1, 1, 4'h4, 1, 6);
        add(1, 4'h0, 0, 0, 0, 0, 1, 4'h0, 0, 0, 0, 4'h0, 0, 7);
        foreach (vecs[n]) begin
            drive(vecs[n].r, vecs[n].v, vecs[n].d, vecs[n].o);
            chk($sformatf("vec%0d outputs", n),
                {grant, out_valid, out_data, out_last, in_ready, busy, out_keep},
                {vecs[n].g, vecs[n].ov, vecs[n].od, vecs[n].ol, vecs[n].ir, vecs[n].b,
                 (vecs[n].ov ? 4'hF : 4'h0)});
            chk($sformatf("vec%0d pkt_count", n), pkt_count, vecs[n].c);
        end
        // backpressure and a 3-cycle source gap on a 5-beat packet from in1
        begin
            int idx = 0, gap = 0, beats = 0, cyc = 0;
            logic rdy = 1'b1;
            logic [3:0] v;
            while (idx < 5 && cyc < 60) begin
                v = (idx == 2 && gap < 3) ? 4'b0000 : 4'b0010;
                if (idx == 2 && gap < 3) gap++;
                drive(1'b1, v, {64'h0, w[idx], 32'h0}, rdy);
                chk("bp grant", grant, cyc > 0 ? 4'b0010 : 4'b0000);
                chk("bp in_ready", in_ready, (cyc > 0 && rdy) ? 4'b0010 : 4'b0000);
                chk("bp out_valid", out_valid, cyc > 0 && v[1]);
                if (out_valid && out_ready) begin
                    if (beats < 5) begin
                        chk($sformatf("bp beat%0d data", beats), out_data, w[beats]);
                        chk($sformatf("bp beat%0d last", beats), out_last, beats == 4);
                    end else chk("bp extra beat", 1, 0);
                    beats++;
                end
                if (v[1] && in_ready[1]) idx++;
                rdy = !rdy;
                cyc++;
            end
            chk("bp timeout", idx, 5);
            chk("bp beat count", beats, 5);
            drive(1'b1, 4'h0, '0, 1'b1);
            chk("bp after grant", {grant, busy}, 5'b0);
            chk("bp pkt_count", pkt_count, 8);
        end
        // asynchronous reset between edges on beat 2 of a 6-beat packet
        drive(1'b1, 4'b0001, {96'h0, 32'd6}, 1'b1);
        chk("rst idle grant", grant, 4'b0000);
        drive(1'b1, 4'b0001, {96'h0, 32'd6}, 1'b1);
        chk("rst header", {grant, out_valid}, {4'b0001, 1'b1});
        drive(1'b1, 4'b0001, {96'h0, 32'h61}, 1'b1);
        chk("rst beat2", {out_valid, out_data}, {1'b1, 32'h61});
        #2 reset = 1'b0;
        #1;
        chk("rst drop", {out_valid, grant, in_ready, busy, out_last, out_keep}, 15'b0);
        chk("rst pkt_count", pkt_count, 0);
        drive(1'b0, 4'b0011, {64'h0, 32'd2, 32'd1}, 1'b1);
        chk("rst held grant", grant, 4'b0000);
        drive(1'b1, 4'b0011, {64'h0, 32'd2, 32'd1}, 1'b1);
        chk("rst release idle", grant, 4'b0000);
        drive(1'b1, 4'b0011, {64'h0, 32'd2, 32'd1}, 1'b1);
        chk("rst first grant", {grant, out_data, out_last}, {4'b0001, 32'd1, 1'b1});
        chk("rst count zero", pkt_count, 0);
        // in1 hogs valid, in3 arrives mid-packet and must be served next
        drive(1'b1, 4'b0010, {32'd1, 32'd0, 32'd2, 32'd1}, 1'b1);
        chk("hog bubble", {grant, pkt_count}, {4'b0000, 32'd1});
        drive(1'b1, 4'b1010, {32'd1, 32'd0, 32'd2, 32'd1}, 1'b1);
        chk("hog in1 header", {grant, out_data, out_last}, {4'b0010, 32'd2, 1'b0});
        drive(1'b1, 4'b1010, {32'd1, 32'd0, 32'h77, 32'd1}, 1'b1);
        chk("hog in1 last", {out_data, out_last}, {32'h77, 1'b1});
        drive(1'b1, 4'b1010, {32'd1, 32'd0, 32'd2, 32'd1}, 1'b1);
        chk("hog bubble2", grant, 4'b0000);
        drive(1'b1, 4'b1010, {32'd1, 32'd0, 32'd2, 32'd1}, 1'b1);
        chk("hog in3 next", {grant, out_data, out_last}, {4'b1000, 32'd1, 1'b1});
        drive(1'b1, 4'b1010, {32'd1, 32'd0, 32'd2, 32'd1}, 1'b1);
        chk("hog bubble3", grant, 4'b0000);
        drive(1'b1, 4'b1010, {32'd1, 32'd0, 32'd2, 32'd1}, 1'b1);
        chk("hog in1 again", {grant, pkt_count}, {4'b0010, 32'd3});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dma_stream_arbiter.md
Name: dma_stream_arbiter

Overview:
- Shares one outbound DMA (AXI-Stream style) channel between NUM_IN length-prefixed packet sources.
- Each packet starts with a header word holding its total beat count, header included.
- Grants one source per packet, round-robin, and passes that packet through combinationally.
- Generates out_last and out_keep for the DMA engine and counts completed packets.

Parameters:
- NUM_IN, 4, number of requesting input streams (2..16).
- DATA_WIDTH, 32, stream word width; multiple of 8.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  in  NUM_IN*DATA_WIDTH  packed input words; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  NUM_IN  per-input valid.
- in_ready  out  NUM_IN  per-input ready.
- out_data  out  DATA_WIDTH  word to the DMA.
- out_valid  out  1  output valid.
- out_ready  in  1  DMA ready.
- out_last  out  1  final beat of the current packet.
- out_keep  out  DATA_WIDTH/8  byte enables.
- grant  out  NUM_IN  one-hot owner of the channel; all-zero when idle.
- busy  out  1  high while in HEADER or PAYLOAD.
- pkt_count  out  32  number of completed packets; wraps modulo 2^32.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; grant=0, busy=0, pkt_count=0, remaining=0.
  - rr_ptr=NUM_IN-1, so input 0 has first priority.
  - Combinational outputs immediately follow: out_valid=0, in_ready=0, out_last=0, out_keep=0.
  - Reset mid-packet abandons the packet; no out_last is emitted.
- Handshake: a beat transfers on a rising clk edge with out_valid && out_ready.
- Data path (purely combinational, zero-latency):
  - When grant[i]=1: out_data=in_data[i], out_valid=in_valid[i], in_ready[i]=out_ready.
  - All non-granted in_ready bits are 0. In IDLE, every in_ready bit is 0 and out_valid=0.
- out_keep is all-ones whenever out_valid=1, otherwise 0.
- State machine, states IDLE, HEADER, PAYLOAD:
  - IDLE:
    - If any in_valid is set, pick the first set index scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_IN.
    - Register grant one-hot and rr_ptr to the winner; go to HEADER.
    - Grant appears exactly 1 cycle after valid is seen in IDLE. No input data moves in IDLE.
  - HEADER:
    - The forwarded word is header value L (unsigned, full DATA_WIDTH).
    - out_last = (L <= 1), combinational on the header beat.
    - On the handshake, if L <= 1: packet complete, go to IDLE.
    - On the handshake, if L >= 2: remaining <= L-1, go to PAYLOAD.
  - PAYLOAD:
    - out_last = (remaining == 1).
    - Each handshake decrements remaining.
    - On the handshake with remaining == 1: packet complete, go to IDLE.
- Packet complete:
  - pkt_count increments; grant and busy clear on the same edge.
  - There is one mandatory idle bubble cycle between packets, even for the same source.
- Stalls:
  - in_valid low or out_ready low inside a packet holds the state, remaining and grant.
  - No timeout; a stalled source owns the channel until its packet completes.
- Fairness: after any input completes a packet, every other input holding valid is served before that input is served again.
- in_valid changes on non-granted inputs have no effect until the next arbitration.
- remaining is DATA_WIDTH bits; L up to 2^DATA_WIDTH-1 is legal, with no overflow.

Test Plan:
- Reset then single packet: in0 sends header 4 plus words A,B,C with out_ready=1. Required: grant=0001 one cycle after valid; 4 beats out; out_last only on C; pkt_count=1; grant=0 next cycle.
- Round-robin: in0..in3 all valid with 2-beat packets. Required: grant order 0001,0010,0100,1000,0001; one idle cycle between packets; pkt_count=5 after five packets.
- Header-only packets: in2 sends header 0, then header 1. Required: each is a single beat with out_last=1 on the header; pkt_count +1 each; state returns to IDLE.
- Backpressure and source gaps: 5-beat packet with out_ready toggling 1,0,1,0 and in_valid low for 3 cycles mid-payload. Required: no beat lost or duplicated; out_last on beat 5 only; in_ready high only for the granted input, only when out_ready=1.
- Async reset mid-packet: assert reset=0 on beat 2 of 6, between clock edges. Required: out_valid, grant and in_ready drop immediately. After release, in0 and in1 valid gives grant=0001 first; pkt_count=0.
- Fairness with a hog: in1 continuously valid, in3 raises valid during in1's packet. Required: in3 is granted next, before in1 is granted again.
